// File: rtl/class_hvec_seq.sv
// Class-hypervector sequencer: walks (class, frame) addresses into the combinational
// generator and streams each returned frame out on a registered valid/ready port.
module class_hvec_seq #(
  parameter int unsigned DI_PARALLEL_W_BITS = 64,
  parameter int unsigned N_CLASSES          = 8,
  parameter int unsigned N_FRAMES           = 3,
  parameter int unsigned CLASS_W            = 3,
  parameter int unsigned FRAME_W            = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          single_i,
  input  logic [CLASS_W-1:0]            class_sel_i,
  input  logic                          abort_i,
  output logic [CLASS_W-1:0]            gen_frame_id_o,
  output logic [FRAME_W-1:0]            gen_frame_index_o,
  input  logic [DI_PARALLEL_W_BITS-1:0] gen_vec_i,
  output logic [DI_PARALLEL_W_BITS-1:0] vec_o,
  output logic                          vec_valid_o,
  input  logic                          vec_ready_i,
  output logic [CLASS_W-1:0]            vec_class_o,
  output logic [FRAME_W-1:0]            vec_frame_o,
  output logic                          vec_last_frame_o,
  output logic                          vec_last_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam logic [CLASS_W-1:0] LAST_CLS = CLASS_W'(N_CLASSES - 1);
  localparam logic [FRAME_W-1:0] LAST_FRM = FRAME_W'(N_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state;
  logic [CLASS_W-1:0]   cls;
  logic [FRAME_W-1:0]   frm;
  logic [CLASS_W-1:0]   cls_end;

  logic sel_bad_c;
  logic ld_c;
  logic last_c;

  // Out-of-range check is done at 32 bits so non-power-of-two class counts work.
  assign sel_bad_c = single_i && (32'(class_sel_i) >= N_CLASSES);
  assign ld_c      = (state == RUN) && (!vec_valid_o || vec_ready_i);
  assign last_c    = (cls == cls_end) && (frm == LAST_FRM);

  assign gen_frame_id_o    = cls;
  assign gen_frame_index_o = frm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cls              <= '0;
      frm              <= '0;
      cls_end          <= '0;
      vec_o            <= '0;
      vec_valid_o      <= 1'b0;
      vec_class_o      <= '0;
      vec_frame_o      <= '0;
      vec_last_frame_o <= 1'b0;
      vec_last_o       <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (abort_i) begin
        state       <= IDLE;
        busy_o      <= 1'b0;
        vec_valid_o <= 1'b0;
        cls         <= '0;
        frm         <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              if (sel_bad_c) begin
                err_o <= 1'b1;
              end else begin
                state   <= RUN;
                busy_o  <= 1'b1;
                cls     <= single_i ? class_sel_i : '0;
                frm     <= '0;
                cls_end <= single_i ? class_sel_i : LAST_CLS;
              end
            end
          end
          RUN: begin
            if (ld_c) begin
              vec_o            <= gen_vec_i;
              vec_class_o      <= cls;
              vec_frame_o      <= frm;
              vec_valid_o      <= 1'b1;
              vec_last_frame_o <= (frm == LAST_FRM);
              vec_last_o       <= last_c;
              // Counters hold on the final load so the address stays on the last frame.
              if (last_c) begin
                state <= DRAIN;
              end else if (frm == LAST_FRM) begin
                frm <= '0;
                cls <= cls + 1'b1;
              end else begin
                frm <= frm + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (vec_valid_o && vec_ready_i) begin
              vec_valid_o <= 1'b0;
              done_o      <= 1'b1;
              busy_o      <= 1'b0;
              state       <= IDLE;
            end
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_class_hvec_seq.sv
// Directed bench for class_hvec_seq: full/single sweeps, backpressure, abort,
// start rejection (6-class instance) and asynchronous reset.
module tb_class_hvec_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, single, abort, ready;
  logic [2:0]  sel;
  logic [2:0]  gen_id, vcls;
  logic [1:0]  gen_idx, vfrm;
  logic [63:0] gen_vec, vec;
  logic        valid, vlf, vlast, busy, done, err;

  logic        start6, abort6, ready6;
  logic [2:0]  gen_id6, vcls6;
  logic [1:0]  gen_idx6, vfrm6;
  logic [63:0] gen_vec6, vec6;
  logic        valid6, vlf6, vlast6, busy6, done6, err6;

  int n_vec = 0;
  int n_err = 0;

  // Generator model: frame content is {class, frame} zero-extended.
  assign gen_vec  = 64'({gen_id, gen_idx});
  assign gen_vec6 = 64'({gen_id6, gen_idx6});

  class_hvec_seq dut (
    .clk(clk), .rst(rst), .start_i(start), .single_i(single), .class_sel_i(sel),
    .abort_i(abort), .gen_frame_id_o(gen_id), .gen_frame_index_o(gen_idx),
    .gen_vec_i(gen_vec), .vec_o(vec), .vec_valid_o(valid), .vec_ready_i(ready),
    .vec_class_o(vcls), .vec_frame_o(vfrm), .vec_last_frame_o(vlf), .vec_last_o(vlast),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  class_hvec_seq #(.N_CLASSES(6)) dut6 (
    .clk(clk), .rst(rst), .start_i(start6), .single_i(single), .class_sel_i(sel),
    .abort_i(abort6), .gen_frame_id_o(gen_id6), .gen_frame_index_o(gen_idx6),
    .gen_vec_i(gen_vec6), .vec_o(vec6), .vec_valid_o(valid6), .vec_ready_i(ready6),
    .vec_class_o(vcls6), .vec_frame_o(vfrm6), .vec_last_frame_o(vlf6), .vec_last_o(vlast6),
    .busy_o(busy6), .done_o(done6), .err_o(err6)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) tick();
    n_vec++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || vec !== 64'd0 ||
        gen_id !== 3'd0 || gen_idx !== 2'd0 || vlast !== 1'b0 || vlf !== 1'b0) begin
      n_err++;
      $display("FAIL reset got valid=%b busy=%b done=%b err=%b vec=%h id=%0d idx=%0d required all 0",
               valid, busy, done, err, vec, gen_id, gen_idx);
    end
    n_vec++;
    if (valid6 !== 1'b0 || busy6 !== 1'b0 || err6 !== 1'b0 || vec6 !== 64'd0) begin
      n_err++;
      $display("FAIL reset6 got valid=%b busy=%b err=%b vec=%h required all 0", valid6, busy6, err6, vec6);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release got valid=%b busy=%b done=%b required 0 0 0", valid, busy, done);
    end
  endtask

  task automatic test_full_sweep;
    logic [2:0] ec;
    logic [1:0] ef;
    ready = 1'b1; single = 1'b0; sel = 3'd0;
    start = 1'b1; tick(); start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_accept got busy=%b valid=%b required busy=1 valid=0", busy, valid);
    end
    tick();
    for (int k = 0; k < 24; k++) begin
      ec = 3'(k / 3);
      ef = 2'(k % 3);
      n_vec++;
      if (valid !== 1'b1 || vcls !== ec || vfrm !== ef || vec !== 64'({ec, ef}) ||
          vlf !== (ef == 2'd2) || vlast !== (k == 23) || done !== 1'b0) begin
        n_err++;
        $display("FAIL full_beat%0d got v=%b c=%0d f=%0d d=%h lf=%b l=%b dn=%b required v=1 c=%0d f=%0d lf=%b l=%b dn=0",
                 k, valid, vcls, vfrm, vec, vlf, vlast, done, ec, ef, (ef == 2'd2), (k == 23));
      end
      tick();
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_done got done=%b busy=%b valid=%b required 1 0 0", done, busy, valid);
    end
    tick();
    n_vec++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_done_pulse got done=%b valid=%b required 0 0", done, valid);
    end
  endtask

  task automatic test_single;
    ready = 1'b1; single = 1'b1; sel = 3'd5;
    start = 1'b1; tick();
    start = 1'b1; tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (valid !== 1'b1 || vcls !== 3'd5 || vfrm !== 2'(k) || vec !== 64'({3'd5, 2'(k)}) ||
          vlf !== (k == 2) || vlast !== (k == 2) || err !== 1'b0) begin
        n_err++;
        $display("FAIL single_beat%0d got v=%b c=%0d f=%0d d=%h lf=%b l=%b err=%b required v=1 c=5 f=%0d lf=%b l=%b err=0",
                 k, valid, vcls, vfrm, vec, vlf, vlast, err, k, (k == 2), (k == 2));
      end
      tick();
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL single_done got done=%b busy=%b valid=%b err=%b required 1 0 0 0", done, busy, valid, err);
    end
    tick();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL single_after got done=%b busy=%b valid=%b err=%b required 0 0 0 0", done, busy, valid, err);
    end
    single = 1'b0; sel = 3'd0;
  endtask

  task automatic test_backpressure;
    int k, cyc;
    logic pv, pr;
    logic [63:0] pd;
    logic [2:0] pc, ec;
    logic [1:0] pf, ef;
    ready = 1'b1; single = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    k = 0; cyc = 0; pv = 1'b0; pr = 1'b1; pd = '0; pc = '0; pf = '0;
    while (k < 24 && cyc < 300) begin
      ready = (cyc < 4) ? (cyc == 0 || cyc == 3) : 1'($urandom_range(0, 1));
      if (pv && !pr) begin
        n_vec++;
        if (valid !== 1'b1 || vec !== pd || vcls !== pc || vfrm !== pf) begin
          n_err++;
          $display("FAIL bp_stall cyc%0d got v=%b d=%h c=%0d f=%0d required v=1 d=%h c=%0d f=%0d",
                   cyc, valid, vec, vcls, vfrm, pd, pc, pf);
        end
      end
      if (valid === 1'b1 && ready) begin
        ec = 3'(k / 3);
        ef = 2'(k % 3);
        n_vec++;
        if (vcls !== ec || vfrm !== ef || vec !== 64'({ec, ef}) || vlast !== (k == 23)) begin
          n_err++;
          $display("FAIL bp_beat%0d got c=%0d f=%0d d=%h l=%b required c=%0d f=%0d l=%b",
                   k, vcls, vfrm, vec, vlast, ec, ef, (k == 23));
        end
        k++;
      end
      pv = valid; pr = ready; pd = vec; pc = vcls; pf = vfrm;
      tick();
      cyc++;
    end
    n_vec++;
    if (k != 24) begin
      n_err++;
      $display("FAIL bp_count got %0d beats required 24 within 300 cycles", k);
    end
    n_vec++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_done got done=%b valid=%b busy=%b required 1 0 0", done, valid, busy);
    end
    ready = 1'b1;
    tick();
  endtask

  task automatic test_abort;
    ready = 1'b1; single = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int k = 0; k < 9; k++) begin
      n_vec++;
      if (valid !== 1'b1 || vcls !== 3'(k / 3) || vfrm !== 2'(k % 3)) begin
        n_err++;
        $display("FAIL abort_pre%0d got v=%b c=%0d f=%0d required v=1 c=%0d f=%0d",
                 k, valid, vcls, vfrm, k / 3, k % 3);
      end
      tick();
    end
    n_vec++;
    if (valid !== 1'b1 || vcls !== 3'd3 || vfrm !== 2'd0) begin
      n_err++;
      $display("FAIL abort_beat10 got v=%b c=%0d f=%0d required v=1 c=3 f=0", valid, vcls, vfrm);
    end
    ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    n_vec++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || gen_id !== 3'd0 || gen_idx !== 2'd0) begin
      n_err++;
      $display("FAIL abort_state got valid=%b busy=%b done=%b id=%0d idx=%0d required 0 0 0 0 0",
               valid, busy, done, gen_id, gen_idx);
    end
    tick();
    n_vec++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_nodone got done=%b valid=%b required 0 0", done, valid);
    end
    ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_vec++;
    if (valid !== 1'b1 || vcls !== 3'd0 || vfrm !== 2'd0 || vec !== 64'd0) begin
      n_err++;
      $display("FAIL abort_restart got v=%b c=%0d f=%0d d=%h required v=1 c=0 f=0 d=0",
               valid, vcls, vfrm, vec);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_cleanup got busy=%b valid=%b required 0 0", busy, valid);
    end
  endtask

  task automatic test_reject;
    logic [2:0] bad [2];
    bad[0] = 3'd7;
    bad[1] = 3'd6;
    ready6 = 1'b1; single = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sel = bad[i];
      start6 = 1'b1; tick(); start6 = 1'b0;
      n_vec++;
      if (err6 !== 1'b1 || busy6 !== 1'b0) begin
        n_err++;
        $display("FAIL reject_sel%0d got err=%b busy=%b required 1 0", bad[i], err6, busy6);
      end
      tick();
      n_vec++;
      if (err6 !== 1'b0 || busy6 !== 1'b0 || valid6 !== 1'b0) begin
        n_err++;
        $display("FAIL reject_pulse%0d got err=%b busy=%b valid=%b required 0 0 0", bad[i], err6, busy6, valid6);
      end
    end
    sel = 3'd5;
    start6 = 1'b1; tick(); start6 = 1'b0;
    n_vec++;
    if (err6 !== 1'b0 || busy6 !== 1'b1) begin
      n_err++;
      $display("FAIL reject_inrange got err=%b busy=%b required 0 1", err6, busy6);
    end
    tick();
    n_vec++;
    if (valid6 !== 1'b1 || vcls6 !== 3'd5 || vfrm6 !== 2'd0) begin
      n_err++;
      $display("FAIL reject_beat got v=%b c=%0d f=%0d required v=1 c=5 f=0", valid6, vcls6, vfrm6);
    end
    abort6 = 1'b1; tick(); abort6 = 1'b0;
    single = 1'b0; sel = 3'd0;
  endtask

  task automatic test_async_reset;
    ready = 1'b1; single = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (valid !== 1'b0 || busy !== 1'b0 || vec !== 64'd0 || vcls !== 3'd0 || vfrm !== 2'd0 ||
        gen_id !== 3'd0 || gen_idx !== 2'd0 || vlast !== 1'b0 || vlf !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst got v=%b busy=%b d=%h c=%0d f=%0d id=%0d idx=%0d required all 0",
               valid, busy, vec, vcls, vfrm, gen_id, gen_idx);
    end
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst_release got busy=%b valid=%b required 0 0", busy, valid);
    end
    test_full_sweep();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; single = 1'b0; sel = 3'd0; abort = 1'b0; ready = 1'b0;
    start6 = 1'b0; abort6 = 1'b0; ready6 = 1'b0;
    test_reset();
    test_full_sweep();
    test_single();
    test_backpressure();
    test_abort();
    test_reject();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
